// File: rtl/dpram_wr_ctrl_if.sv
// Valid/ready word stream feeding the dual-port RAM write controller.
// The master drives beats in; the slave (the controller) answers with in_ready.
interface dpram_wr_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/dpram_wr_ctrl.sv
// Write-side controller of the dual-port RAM: accepts a valid/ready stream, drives the RAM write
// port, exports a Gray write pointer and derives level/full from the synchronised reader pointer.
module dpram_wr_ctrl #(
  parameter int  WIDTH     = 16,
  parameter int  DEPTH     = 8,
  parameter int  AF_MARGIN = 2,
  localparam int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic             wr_clk,
  input  logic             clr,
  input  logic             en,
  dpram_wr_ctrl_if.slave   in_bus,
  input  logic [PTR_W-1:0] rd_ptr_gray,
  output logic             write,
  output logic [3:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [PTR_W-1:0] wr_ptr_gray,
  output logic [PTR_W-1:0] level,
  output logic             full,
  output logic             almost_full
);

  localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LEVEL   = PTR_W'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FULL
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wr_bin, wr_bin_nxt;
  logic [PTR_W-1:0] rd_sync1, rd_sync2, rd_bin;
  logic [PTR_W-1:0] level_nxt;
  logic             full_nxt, almost_full_nxt;
  logic             accept;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // in_ready is decoded straight from the state register, so it is glitch-free.
  assign in_bus.in_ready = (state == ST_ACTIVE);
  assign accept          = in_bus.in_valid & in_bus.in_ready;

  // Level and full come from the post-accept pointer, so the accept that fills the RAM
  // also takes the FSM out of ACTIVE at the same edge: no accept can ever happen when full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt       = state;
    wr_bin_nxt      = wr_bin + PTR_W'(accept);
    rd_bin          = gray2bin(rd_sync2);
    level_nxt       = wr_bin_nxt - rd_bin;
    full_nxt        = (level_nxt == FULL_LEVEL);
    almost_full_nxt = (level_nxt >= AF_LEVEL);

    unique case (state)
      ST_IDLE:   if (en) state_nxt = full_nxt ? ST_FULL : ST_ACTIVE;
      ST_ACTIVE: begin
        if (!en)           state_nxt = ST_IDLE;
        else if (full_nxt) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (!en)            state_nxt = ST_IDLE;
        else if (!full_nxt) state_nxt = ST_ACTIVE;
      end
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge wr_clk or posedge clr) begin
    if (clr) begin
      state       <= ST_IDLE;
      wr_bin      <= '0;
      rd_sync1    <= '0;
      rd_sync2    <= '0;
      write       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_ptr_gray <= '0;
      level       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_bin      <= wr_bin_nxt;
      rd_sync1    <= rd_ptr_gray;
      rd_sync2    <= rd_sync1;
      write       <= accept;
      wr_ptr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
      level       <= level_nxt;
      full        <= full_nxt;
      almost_full <= almost_full_nxt;
      if (accept) begin
        wr_addr <= 4'(wr_bin[PTR_W-2:0]);
        wr_data <= in_bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_dpram_wr_ctrl.sv
// Bench for dpram_wr_ctrl: directed scenarios plus a random phase, every output compared
// each cycle against a counting model of beats written, reader position and synchroniser delay.
module tb_dpram_wr_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AF_MARGIN = 2;
  localparam int PTR_W = 4;

  logic             wr_clk = 1'b0;
  logic             clr = 1'b1;
  logic             en = 1'b0;
  logic [PTR_W-1:0] rd_ptr_gray = '0;
  logic             write;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [PTR_W-1:0] wr_ptr_gray;
  logic [PTR_W-1:0] level;
  logic             full;
  logic             almost_full;

  dpram_wr_ctrl_if #(.WIDTH(WIDTH)) in_bus ();

  dpram_wr_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .wr_clk      (wr_clk),
    .clr         (clr),
    .en          (en),
    .in_bus      (in_bus.slave),
    .rd_ptr_gray (rd_ptr_gray),
    .write       (write),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ptr_gray (wr_ptr_gray),
    .level       (level),
    .full        (full),
    .almost_full (almost_full)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: beats written so far, reader position, two-cycle synchroniser view.
  int  wr_cnt, rd_ptr, rd_s1, rd_s2;
  int  m_level, m_addr, m_data;
  bit  m_write, m_full, m_af, m_ready;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int from_gray(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    wr_cnt = 0; rd_ptr = 0; rd_s1 = 0; rd_s2 = 0;
    m_level = 0; m_addr = 0; m_data = 0;
    m_write = 0; m_full = 0; m_af = 0; m_ready = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = in_bus.in_valid && m_ready;
    m_write = acc;
    if (acc) begin
      m_addr = wr_cnt % DEPTH;
      m_data = int'(in_bus.in_data);
      wr_cnt++;
    end
    m_level = ((wr_cnt % 16) - rd_s2 + 16) % 16;
    rd_s2   = rd_s1;
    rd_s1   = from_gray(int'(rd_ptr_gray));
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= DEPTH - AF_MARGIN);
    m_ready = en && !m_full;
  endtask

  task automatic check_all();
    check("write",       write,           m_write);
    check("wr_addr",     wr_addr,         m_addr);
    check("wr_data",     wr_data,         m_data);
    check("wr_ptr_gray", wr_ptr_gray,     to_gray(wr_cnt % 16));
    check("level",       level,           m_level);
    check("full",        full,            m_full);
    check("almost_full", almost_full,     m_af);
    check("in_ready",    in_bus.in_ready, m_ready);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_write"},   write,           0);
    check({tag, "_addr"},    wr_addr,         0);
    check({tag, "_data"},    wr_data,         0);
    check({tag, "_gray"},    wr_ptr_gray,     0);
    check({tag, "_level"},   level,           0);
    check({tag, "_full"},    full,            0);
    check({tag, "_af"},      almost_full,     0);
    check({tag, "_ready"},   in_bus.in_ready, 0);
  endtask

  task automatic step();
    @(posedge wr_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_reader(input int p);
    rd_ptr      = p;
    rd_ptr_gray = PTR_W'(to_gray(p % 16));
  endtask

  initial begin
    int guard;
    model_reset();
    in_bus.in_valid = 1'b0;
    in_bus.in_data  = '0;
    #2;
    check_zero("reset");
    @(negedge wr_clk);
    clr = 1'b0;

    // Fill: 0x1111..0x8888 back-to-back.
    en = 1'b1;
    guard = 0;
    while (wr_cnt < 8 && guard < 40) begin
      in_bus.in_valid = 1'b1;
      in_bus.in_data  = WIDTH'((wr_cnt + 1) * 16'h1111);
      step();
      guard++;
    end
    in_bus.in_valid = 1'b0;
    check("fill_full", full, 1);
    check("fill_ready", in_bus.in_ready, 0);

    // Reader frees two entries; level drops after the synchroniser.
    set_reader(2);
    for (int i = 0; i < 4; i++) step();
    check("drain_level", level, 6);

    // Wrap: write at address 0 again, then refill.
    in_bus.in_valid = 1'b1;
    in_bus.in_data  = 16'hAAAA;
    guard = 0;
    while (!m_write && guard < 10) begin step(); guard++; end
    check("wrap_addr", wr_addr, 0);
    guard = 0;
    while (!m_full && guard < 10) begin
      in_bus.in_data = WIDTH'($urandom);
      step();
      guard++;
    end

    // Held valid while full: nothing is accepted.
    for (int i = 0; i < 10; i++) begin
      in_bus.in_data = WIDTH'($urandom);
      step();
    end
    check("hold_level", level, 8);

    // Make room, then drop en in the same cycle as an accept of 0x5A5A.
    in_bus.in_valid = 1'b0;
    set_reader(6);
    for (int i = 0; i < 4; i++) step();
    in_bus.in_valid = 1'b1;
    in_bus.in_data  = 16'h5A5A;
    en = 1'b0;
    step();
    step();
    check("en_drop_data", wr_data, 16'h5A5A);
    for (int i = 0; i < 5; i++) begin
      in_bus.in_data = WIDTH'($urandom);
      step();
    end

    // Random traffic with a reader that advances concurrently.
    for (int i = 0; i < 300; i++) begin
      in_bus.in_valid = ($urandom_range(0, 3) != 0);
      in_bus.in_data  = WIDTH'($urandom);
      en              = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) == 0)
        set_reader(rd_ptr + $urandom_range(0, wr_cnt - rd_ptr));
      step();
    end

    // Empty, refill to level 5, then asynchronous clear mid-burst.
    en = 1'b1;
    in_bus.in_valid = 1'b0;
    set_reader(wr_cnt);
    for (int i = 0; i < 4; i++) step();
    in_bus.in_valid = 1'b1;
    guard = 0;
    while (m_level < 5 && guard < 20) begin
      in_bus.in_data = WIDTH'($urandom);
      step();
      guard++;
    end
    check("pre_clr_level", level, 5);
    @(posedge wr_clk);
    #3;
    clr = 1'b1;
    #1;
    check_zero("async_clr");
    model_reset();
    rd_ptr_gray = '0;
    in_bus.in_data = 16'hC3C3;
    @(negedge wr_clk);
    clr = 1'b0;
    guard = 0;
    while (!m_write && guard < 10) begin step(); guard++; end
    check("post_clr_write", write, 1);
    check("post_clr_addr", wr_addr, 0);
    in_bus.in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
